muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle multiply/divide engine with architectural HI/LO registers for the MIPS CPU. It accepts MULT/MULTU/DIV/DIVU requests from the execute stage and computes them iteratively over 33 cycles. It holds the pipeline through `busy`, then commits the 64-bit result into HI/LO. It also services MTHI/MTLO writes, and its `hi`/`lo` outputs feed MFHI/MFLO directly.

## Interface
Parameters: none (32-bit datapath fixed).
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mult`  in  1  start signed multiply, HI:LO = a*b
- `multu`  in  1  start unsigned multiply
- `div`  in  1  start signed divide, LO = a/b, HI = a%b
- `divu`  in  1  start unsigned divide
- `mthi`  in  1  write `a` into HI
- `mtlo`  in  1  write `a` into LO
- `a`  in  32  rs data
- `b`  in  32  rt data
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `busy`  out  1  operation in progress; pipeline must stall
- `done`  out  1  one-cycle pulse; HI/LO just updated by a mul/div

## Operation
- States:
  - IDLE: accepts requests.
  - ITER: runs 32 iterations, counter 0..31.
  - FIX: applies sign correction and commits the result.
- Start (IDLE only):
  - Any of mult/multu/div/divu high at an edge latches the op, `a`, `b`, and the sign flags, and loads magnitudes (signed ops: two's-complement negate of negative operands). Counter clears; next state is ITER.
  - Priority when several ops are high: mult > multu > div > divu.
- MTHI/MTLO:
  - In IDLE with no mul/div op high, mthi writes HI = a and mtlo writes LO = a at the edge. Both may be high together and both write.
  - If a mul/div op is high in the same cycle, the op starts and mthi/mtlo are ignored.
  - In ITER/FIX, mthi/mtlo are ignored.
- Requests in ITER/FIX are ignored. The pipeline is stalled and re-presents nothing.
- Multiply: shift-add, one multiplier bit per ITER cycle, LSB first, 64-bit accumulator. Signed: negate the 64-bit product if the sign of a XOR the sign of b is 1.
- Divide: restoring, one quotient bit per ITER cycle, MSB first, 33-bit partial remainder.
  - Signed quotient is negated if the signs differ.
  - Signed remainder takes the sign of `a`.
- Divide by zero (no trap): the natural restoring result, then sign fix.
  - divu: LO = 0xFFFFFFFF, HI = a.
  - div: LO = 0x00000001 if a[31], else 0xFFFFFFFF; HI = a.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- After the 32nd ITER edge the state is FIX. At the FIX edge, HI/LO are written, `done` is set, and the state returns to IDLE.
- HI/LO change only via reset, MTHI/MTLO, or a FIX commit.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state IDLE, counter 0.
- Edge E0 samples the request. busy = (state != IDLE), so busy is high in the 33 cycles between E0 and E33 (32 ITER + 1 FIX).
- Edge E33 commits HI/LO. In the cycle after E33, busy = 0, done = 1, and hi/lo show the result.
- done is high for exactly one cycle. A new request may be sampled at the edge ending that cycle.
- Back-to-back ops: a second op at edge E34 produces done after E67.
- MTHI/MTLO have one-edge latency: the value is visible on hi/lo in the next cycle.
- Reset mid-operation (any state): the operation aborts and all outputs return to their reset values at that edge. No partial HI/LO commit.
- `a`/`b` may change after E0 without effect; operands are held internally.

## Test plan
- Signed multiply: mult a=0xFFFFFFFE, b=3 → after 33 busy cycles, done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: multu a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; a second op immediately after done is accepted.
- Signed/unsigned divide:
  - div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu a=100, b=7 → LO=14, HI=2.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero:
  - divu a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678.
  - div a=0xFFFFFFF0, b=0 → LO=1, HI=0xFFFFFFF0.
- MTHI/MTLO and collisions:
  - mthi a=0xAAAA0000 in IDLE → HI=0xAAAA0000 next cycle, busy stays 0.
  - mtlo during busy → LO unchanged.
  - mthi together with mult → mult runs, HI receives the product.
- Reset mid-op: start multu, assert rst on the 10th busy cycle → next cycle hi=lo=0, busy=0, done=0; no done pulse follows.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative 32x32 multiply / divide engine holding the architectural HI/LO pair.
// A mul/div op runs 32 ITER cycles plus one FIX cycle and then commits HI/LO with a done pulse.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        mult,
   input  logic        multu,
   input  logic        div,
   input  logic        divu,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] opb;
   logic [63:0] acc;
   logic [31:0] rem;

   logic        start;
   logic        op_signed;
   logic        sel_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Priority mult > multu > div > divu decides signedness and op kind.
   assign start     = mult | multu | div | divu;
   assign op_signed = mult | (~multu & div);
   assign sel_div   = ~mult & ~multu;
   assign a_neg     = op_signed & a[31];
   assign b_neg     = op_signed & b[31];
   assign a_mag     = a_neg ? (32'd0 - a) : a;
   assign b_mag     = b_neg ? (32'd0 - b) : b;

   // Multiply: acc = {partial product high, remaining multiplier bits}, shifted right each step.
   assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);

   // Divide: remainder stays below the divisor, so the trial difference sign bit is the quotient bit.
   assign div_shift = {rem, acc[31]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_ge    = ~div_diff[32];

   assign prod_fix  = neg_q ? (64'd0 - acc) : acc;
   assign quo_fix   = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
   assign rem_fix   = neg_r ? (32'd0 - rem) : rem;

   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         opb    <= 32'd0;
         acc    <= 64'd0;
         rem    <= 32'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= sel_div;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  opb    <= b_mag;
                  acc    <= {32'd0, a_mag};
                  rem    <= 32'd0;
                  cnt    <= 5'd0;
                  state  <= ITER;
               end else begin
                  if (mthi) hi <= a;
                  if (mtlo) lo <= a;
               end
            end
            ITER: begin
               if (is_div) begin
                  rem        <= div_ge ? div_diff[31:0] : div_shift[31:0];
                  acc[31:0]  <= {acc[30:0], div_ge};
               end else begin
                  acc <= {mul_sum, acc[31:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: each op is launched at a negedge, timed, and its HI/LO
// commit compared against hand-computed values; requests during busy are randomised noise.
module tb_muldiv_seq;

   logic        clk;
   logic        rst;
   logic        mult, multu, div, divu, mthi, mtlo;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done;

   int vectors;
   int miscompares;

   muldiv_seq dut (
      .clk   (clk),
      .rst   (rst),
      .mult  (mult),
      .multu (multu),
      .div   (div),
      .divu  (divu),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .a     (a),
      .b     (b),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      {mult, multu, div, divu, mthi, mtlo} = 6'b0;
      a = 32'd0;
      b = 32'd0;
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_op(input logic [3:0] ops, input logic hi_w, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input string tag);
      logic [31:0] h0, l0;
      logic        hold_ok;
      int          cycles;
      {mult, multu, div, divu} = ops;
      mthi = hi_w;
      mtlo = 1'b0;
      a = av;
      b = bv;
      h0 = hi;
      l0 = lo;
      hold_ok = 1'b1;
      cycles = 0;
      @(negedge clk);
      check({tag, "_done_low_at_start"}, {31'd0, done}, 32'd0);
      while (busy && cycles < 40) begin
         cycles++;
         if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
         {mult, multu, div, divu} = 4'($urandom_range(0, 15));
         mthi = 1'($urandom_range(0, 1));
         mtlo = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         @(negedge clk);
      end
      clear_inputs();
      check({tag, "_busy_cycles"}, 32'(cycles), 32'd33);
      check({tag, "_hilo_held"}, {31'd0, hold_ok}, 32'd1);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      logic seen_done;
      vectors = 0;
      miscompares = 0;
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      mthi = 1'b1;
      a = 32'hAAAA_0000;
      @(negedge clk);
      clear_inputs();
      check("mthi_hi", hi, 32'hAAAA_0000);
      check("mthi_lo", lo, 32'd0);
      check("mthi_busy", {31'd0, busy}, 32'd0);

      mtlo = 1'b1;
      a = 32'h5555_5555;
      @(negedge clk);
      clear_inputs();
      check("mtlo_lo", lo, 32'h5555_5555);
      check("mtlo_hi", hi, 32'hAAAA_0000);

      // mthi collides with mult: the multiply wins and HI ends up with the product.
      run_op(4'b1000, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
      run_op(4'b0100, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
      run_op(4'b0010, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7");
      run_op(4'b0001, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
      run_op(4'b0010, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
      run_op(4'b0001, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
      run_op(4'b0010, 1'b0, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'h0000_0001, "div_by0");
      // Several ops at once: mult has priority, so this is a signed 7 * -3.
      run_op(4'b1111, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_prio");
      run_op(4'b0011, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_prio");
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      // Abort on the 10th busy cycle: no partial commit, no later done.
      multu = 1'b1;
      a = 32'h0001_0000;
      b = 32'h0001_0000;
      @(negedge clk);
      clear_inputs();
      repeat (9) @(negedge clk);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", {31'd0, seen_done}, 32'd0);

      run_op(4'b0100, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
